wb_stream_burst_writer: RTL and testbench
=========================================

WB_STREAM_BURST_WRITER -- requirements
Module: wb_stream_burst_writer

Interface
REQ-001 SHALL have parameters: WB_AW, default 32, address width; WB_DW, default 32, data width (32 or 64); FIFO_AW, default 4, FIFO depth log2 (must be >0); MAX_BURST_LEN, default 16, max beats per burst; TO_W, default 16, timeout counter width.
REQ-002 SHALL use one clock; reset is asynchronous and active-low. Ports, one per line:
REQ-003 wb_clk_i  in  1  system clock.
REQ-004 wb_rst_n_i  in  1  async active-low reset.
REQ-005 wbm_adr_o  out  WB_AW; wbm_dat_o  out  WB_DW; wbm_sel_o  out  WB_DW/8; wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1; wbm_cti_o  out  3; wbm_bte_o  out  2: Wishbone B3 master write.
REQ-006 wbm_dat_i  in  WB_DW (unused); wbm_ack_i, wbm_err_i, wbm_rty_i  in  1: slave responses.
REQ-007 fifo_d  in  WB_DW  first-word-fall-through FIFO data; fifo_rd  out  1  pop strobe; fifo_cnt  in  FIFO_AW+1  FIFO fill level in words.
REQ-008 enable  in  1  start pulse; stop  in  1  stop request; cont  in  1  continuous (ring) mode; timeout_cyc  in  TO_W  partial-burst flush delay, 0 = disabled.
REQ-009 start_adr, buf_size (bytes, multiple of WB_DW/8), burst_size (words)  in  WB_AW  configuration.
REQ-010 busy  out  1; tx_cnt  out  WB_AW  word index; irq  out  1  wrap pulse; err  out  1  sticky bus error.

Function
REQ-011 SHALL define BPW = WB_DW/8, NW = buf_size/BPW; wbm_adr_o = start_adr + tx_cnt*BPW, truncated to WB_AW.
REQ-012 SHALL hold effective burst length BL = clamp(burst_size, 1, MAX_BURST_LEN); burst_size 0 behaves as 1.
REQ-013 SHALL implement FSM S_IDLE, S_WAIT, S_BURST; active = (state == S_BURST).
REQ-014 S_IDLE: enable -> S_WAIT, busy<=1, tx_cnt<=0, err<=0; enable in any other state ignored.
REQ-015 S_WAIT: room = NW - tx_cnt; want = min(BL, room); if fifo_cnt >= want -> S_BURST with latched len = want.
REQ-016 S_WAIT: timeout counter increments each cycle fifo_cnt>0 and fifo_cnt<want; clears otherwise and on leaving S_WAIT; reaching timeout_cyc (nonzero) -> S_BURST with len = fifo_cnt.
REQ-017 S_WAIT: stop -> S_IDLE, busy<=0, same cycle priority over burst start.
REQ-018 wbm_cyc_o = wbm_stb_o = wbm_we_o = active; wbm_sel_o all ones; wbm_bte_o = 2'b00; wbm_dat_o = fifo_d.
REQ-019 wbm_cti_o = 3'b000 when inactive, 3'b111 on last beat (beat counter == len-1, incl. len 1), else 3'b010.
REQ-020 fifo_rd = active & wbm_ack_i; exactly one pop per acked beat.
REQ-021 On ack: tx_cnt <= (tx_cnt == NW-1) ? 0 : tx_cnt+1; wrap asserts irq for exactly one cycle.
REQ-022 Bursts SHALL never cross the buffer end (guaranteed by REQ-015/016 room limit).
REQ-023 wbm_rty_i without ack: beat not counted, strobe held, same address/data reissued.
REQ-024 Last beat acked -> S_IDLE (busy<=0) if wrap occurred and cont=0, or stop seen during burst; else S_WAIT.
REQ-025 stop during S_BURST SHALL be latched and honoured at burst end; burst never truncated by stop.
REQ-026 wbm_err_i during S_BURST: no pop, tx_cnt unchanged, err<=1, S_IDLE, busy<=0.
REQ-027 ack and err same cycle: err wins, beat not counted.

Reset
REQ-028 wb_rst_n_i low SHALL asynchronously force state S_IDLE, busy 0, tx_cnt 0, irq 0, err 0, beat and timeout counters 0, stop latch 0; all Wishbone strobes low, wbm_cti_o 3'b000.
REQ-029 Reset mid-burst SHALL drop cyc/stb immediately without popping FIFO.

Verification
REQ-030 NW=8, BL=4, cont=0, fifo_cnt=8, always-ack slave -> two 4-beat bursts, cti 010,010,010,111 each, addrs start_adr+0..28, irq one cycle after 8th ack, busy falls.
REQ-031 BL=1 -> every beat single-cycle cti 111, cyc drops between beats.
REQ-032 BL=8, fifo_cnt=3 static, timeout_cyc=10 -> 3-beat burst starts after 10 cycles in S_WAIT, cti 010,010,111.
REQ-033 NW=6, BL=4, cont=1 -> bursts of 4,2,4,... ; second burst ends at addr start_adr+20, tx_cnt wraps to 0, irq pulses, busy stays 1.
REQ-034 err on beat 2 of 4 -> err=1, busy=0, tx_cnt=1, 1 pop total; next enable clears err.
REQ-035 rty on beat 1 for 3 cycles then ack; and async reset mid-burst -> same addr reissued, single pop; reset gives cyc=0 immediately.

Source files
------------

// File: rtl/wb_stream_burst_writer_if.sv
// Wishbone B3 master-write bus bundle used by wb_stream_burst_writer.
//
// Signals:
//   wbm_adr_o  WB_AW     beat address
//   wbm_dat_o  WB_DW     write data
//   wbm_sel_o  WB_DW/8   byte selects
//   wbm_we_o, wbm_cyc_o, wbm_stb_o   cycle qualifiers
//   wbm_cti_o  3         cycle type identifier
//   wbm_bte_o  2         burst type extension
//   wbm_dat_i  WB_DW     read data (a write-only master ignores it)
//   wbm_ack_i, wbm_err_i, wbm_rty_i  slave responses
//
// Modports: master (the burst writer), slave (the bus target / bench).
interface wb_stream_burst_writer_if #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
) ();

  logic [WB_AW-1:0]   wbm_adr_o;
  logic [WB_DW-1:0]   wbm_dat_o;
  logic [WB_DW/8-1:0] wbm_sel_o;
  logic               wbm_we_o;
  logic               wbm_cyc_o;
  logic               wbm_stb_o;
  logic [2:0]         wbm_cti_o;
  logic [1:0]         wbm_bte_o;
  logic [WB_DW-1:0]   wbm_dat_i;
  logic               wbm_ack_i;
  logic               wbm_err_i;
  logic               wbm_rty_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
           wbm_cti_o, wbm_bte_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
           wbm_cti_o, wbm_bte_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );

endinterface

// File: rtl/wb_stream_burst_writer.sv
// Drains a first-word-fall-through FIFO into a circular memory buffer using
// Wishbone B3 incrementing write bursts.
//
// Ports:
//   wb_clk_i     system clock
//   wb_rst_n_i   asynchronous active-low reset
//   wbm          Wishbone master-write bus (wb_stream_burst_writer_if.master)
//   fifo_d       FIFO head word            fifo_rd   pop strobe (one per acked beat)
//   fifo_cnt     FIFO fill level in words
//   enable       start pulse (honoured only when idle)
//   stop         stop request (immediate when waiting, at burst end otherwise)
//   cont         continuous ring mode: keep going after the buffer wraps
//   timeout_cyc  cycles to wait before flushing a partial burst, 0 = never
//   start_adr    buffer base address
//   buf_size     buffer size in bytes (multiple of the word size)
//   burst_size   requested burst length in words
//   busy         transfer session in progress
//   tx_cnt       index of the next word to be written
//   irq          one-cycle pulse when the buffer wraps
//   err          sticky bus error flag, cleared by the next enable
module wb_stream_burst_writer #(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 16,
  parameter int TO_W          = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  wb_stream_burst_writer_if.master  wbm,
  input  logic [WB_DW-1:0]          fifo_d,
  output logic                      fifo_rd,
  input  logic [FIFO_AW:0]          fifo_cnt,
  input  logic                      enable,
  input  logic                      stop,
  input  logic                      cont,
  input  logic [TO_W-1:0]           timeout_cyc,
  input  logic [WB_AW-1:0]          start_adr,
  input  logic [WB_AW-1:0]          buf_size,
  input  logic [WB_AW-1:0]          burst_size,
  output logic                      busy,
  output logic [WB_AW-1:0]          tx_cnt,
  output logic                      irq,
  output logic                      err
);

  localparam int BPW       = WB_DW / 8;
  localparam int BPW_SHIFT = $clog2(BPW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_t;

  state_t state, state_nxt;

  logic [WB_AW-1:0] nw;
  logic [WB_AW-1:0] bl;
  logic [WB_AW-1:0] room;
  logic [WB_AW-1:0] want;
  logic [WB_AW-1:0] fifo_lvl;
  logic [WB_AW-1:0] len;
  logic [WB_AW-1:0] beat_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             stop_lat;

  logic active;
  logic last_beat;
  logic beat_ok;
  logic bus_err;
  logic wrap;
  logic start_full;
  logic to_count;
  logic start_flush;
  logic burst_end;
  logic finish;

  // Read data and retry carry no information for a write master: a retried
  // beat is simply left on the bus until it is acked or errored.
  logic unused_bus_inputs;
  assign unused_bus_inputs = ^{wbm.wbm_dat_i, wbm.wbm_rty_i};

  // Burst sizing: a burst never runs past the end of the ring buffer, so the
  // wrap (and irq) can only coincide with the last beat of a burst.
  always_comb begin
    nw = buf_size / WB_AW'(BPW);
    if (burst_size == '0)
      bl = WB_AW'(1);
    else if (burst_size > WB_AW'(MAX_BURST_LEN))
      bl = WB_AW'(MAX_BURST_LEN);
    else
      bl = burst_size;
    room     = nw - tx_cnt;
    want     = (bl < room) ? bl : room;
    fifo_lvl = WB_AW'(fifo_cnt);
  end

  assign active      = (state == S_BURST);
  assign last_beat   = (beat_cnt == len - WB_AW'(1));
  assign bus_err     = active & wbm.wbm_err_i;
  assign beat_ok     = active & wbm.wbm_ack_i & ~wbm.wbm_err_i;
  assign wrap        = (tx_cnt == nw - WB_AW'(1));
  assign start_full  = (fifo_lvl >= want);
  assign to_count    = (fifo_cnt != '0) && (fifo_lvl < want);
  // Fire on the cycle the counter would reach timeout_cyc, so the wait lasts
  // exactly timeout_cyc cycles of partial data.
  assign start_flush = to_count && (timeout_cyc != '0) &&
                       ((to_cnt + TO_W'(1)) == timeout_cyc);
  assign burst_end   = beat_ok & last_beat;
  // A stop arriving on the final beat counts the same as one latched earlier.
  assign finish      = (wrap & ~cont) | stop_lat | stop;

  assign fifo_rd = beat_ok;

  assign wbm.wbm_cyc_o = active;
  assign wbm.wbm_stb_o = active;
  assign wbm.wbm_we_o  = active;
  assign wbm.wbm_sel_o = '1;
  assign wbm.wbm_bte_o = 2'b00;
  assign wbm.wbm_dat_o = fifo_d;
  assign wbm.wbm_adr_o = start_adr + (tx_cnt << BPW_SHIFT);
  assign wbm.wbm_cti_o = !active  ? 3'b000 :
                         last_beat ? 3'b111 : 3'b010;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enable)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (stop)
          state_nxt = S_IDLE;
        else if (start_full || start_flush)
          state_nxt = S_BURST;
      end
      S_BURST: begin
        if (bus_err)
          state_nxt = S_IDLE;
        else if (burst_end)
          state_nxt = finish ? S_IDLE : S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Session bookkeeping: counters, burst length latch, stop latch and flags.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      busy     <= 1'b0;
      tx_cnt   <= '0;
      irq      <= 1'b0;
      err      <= 1'b0;
      len      <= '0;
      beat_cnt <= '0;
      to_cnt   <= '0;
      stop_lat <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            busy     <= 1'b1;
            tx_cnt   <= '0;
            err      <= 1'b0;
            to_cnt   <= '0;
            stop_lat <= 1'b0;
          end
        end
        S_WAIT: begin
          if (stop) begin
            busy   <= 1'b0;
            to_cnt <= '0;
          end else if (start_full) begin
            len      <= want;
            beat_cnt <= '0;
            to_cnt   <= '0;
          end else if (start_flush) begin
            len      <= fifo_lvl;
            beat_cnt <= '0;
            to_cnt   <= '0;
          end else if (to_count) begin
            to_cnt <= to_cnt + TO_W'(1);
          end else begin
            to_cnt <= '0;
          end
        end
        S_BURST: begin
          if (bus_err) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            stop_lat <= 1'b0;
          end else begin
            if (stop)
              stop_lat <= 1'b1;
            if (beat_ok) begin
              tx_cnt   <= wrap ? '0 : tx_cnt + WB_AW'(1);
              irq      <= wrap;
              beat_cnt <= beat_cnt + WB_AW'(1);
              if (last_beat) begin
                stop_lat <= 1'b0;
                if (finish)
                  busy <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stream_burst_writer.sv
// Self-checking bench for wb_stream_burst_writer: a random-latency Wishbone
// slave with a scoreboard of expected beats, a FIFO model, and directed
// scenarios (plain, single-beat, timeout flush, ring mode, clamp, error,
// retry, reset mid-burst, stop mid-burst).
module tb_wb_stream_burst_writer;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int FAW = 4;
  localparam int MBL = 16;
  localparam int TOW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stream_burst_writer_if #(.WB_AW(AW), .WB_DW(DW)) wb ();

  logic [DW-1:0]  fifo_d = '0;
  logic           fifo_rd;
  logic [FAW:0]   fifo_cnt = '0;
  logic           enable = 1'b0;
  logic           stop = 1'b0;
  logic           cont = 1'b0;
  logic [TOW-1:0] timeout_cyc = '0;
  logic [AW-1:0]  start_adr = '0;
  logic [AW-1:0]  buf_size = '0;
  logic [AW-1:0]  burst_size = '0;
  logic           busy;
  logic [AW-1:0]  tx_cnt;
  logic           irq;
  logic           err;

  wb_stream_burst_writer #(
    .WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW), .MAX_BURST_LEN(MBL), .TO_W(TOW)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbm        (wb),
    .fifo_d     (fifo_d),
    .fifo_rd    (fifo_rd),
    .fifo_cnt   (fifo_cnt),
    .enable     (enable),
    .stop       (stop),
    .cont       (cont),
    .timeout_cyc(timeout_cyc),
    .start_adr  (start_adr),
    .buf_size   (buf_size),
    .burst_size (burst_size),
    .busy       (busy),
    .tx_cnt     (tx_cnt),
    .irq        (irq),
    .err        (err)
  );

  typedef struct {
    logic [AW-1:0] adr;
    logic [2:0]    cti;
    bit            wrap;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] exp_data[$];
  logic [DW-1:0] fifo_q[$];

  int checks = 0;
  int failures = 0;
  int beat_idx = 0;
  int pop_cnt = 0;
  int irq_seen = 0;
  int first_seen = -1;
  int cyc_num = 0;
  int t0 = 0;
  int ack_pct = 100;
  int err_on_beat = -1;
  int rty_on_beat = -1;
  int rty_cycles = 0;
  int rty_done = 0;
  bit irq_due = 1'b0;
  bit last_due = 1'b0;

  always @(posedge clk) cyc_num <= cyc_num + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic void fifo_refresh();
    fifo_d = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    if (fifo_q.size() > (1 << FAW))
      fifo_cnt = (FAW+1)'(1 << FAW);
    else
      fifo_cnt = (FAW+1)'(fifo_q.size());
  endfunction

  // Reference model: walk the ring word by word, cutting it into bursts of
  // min(effective burst length, words left before the buffer end).
  function automatic void plan_bursts(input logic [AW-1:0] base, input int nw,
                                      input int bl_req, input int total);
    int bl;
    int pos;
    int done;
    int len;
    bl   = (bl_req < 1) ? 1 : ((bl_req > MBL) ? MBL : bl_req);
    pos  = 0;
    done = 0;
    while (done < total) begin
      len = (bl < nw - pos) ? bl : nw - pos;
      for (int i = 0; i < len && done < total; i++) begin
        beat_t b;
        b.adr  = base + AW'(pos * (DW / 8));
        b.cti  = (i == len - 1) ? 3'b111 : 3'b010;
        b.wrap = (pos == nw - 1);
        exp_q.push_back(b);
        pos  = (pos + 1) % nw;
        done++;
      end
    end
  endfunction

  task automatic apply_stimulus(input logic [AW-1:0] base, input int nw, input int bs,
                                input bit c, input int to, input int nwords);
    logic [DW-1:0] w;
    start_adr   = base;
    buf_size    = AW'(nw * (DW / 8));
    burst_size  = AW'(bs);
    cont        = c;
    timeout_cyc = TOW'(to);
    for (int i = 0; i < nwords; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      exp_data.push_back(w);
    end
    fifo_refresh();
    beat_idx   = 0;
    pop_cnt    = 0;
    irq_seen   = 0;
    first_seen = -1;
    ack_pct    = 40 + $urandom_range(60);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc_num;
    check_output("busy_after_enable", busy, 1);
    check_output("err_clear_on_enable", err, 0);
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (beat_idx < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_output("beats_reached", (beat_idx >= n), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_output("busy_fall", busy, 0);
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic flush_model();
    exp_q.delete();
    exp_data.delete();
    fifo_q.delete();
    fifo_refresh();
  endtask

  // Slave + monitor: chooses a response each cycle, scores accepted beats
  // against the plan, and owns FIFO pops.
  initial begin
    bit pop_now;
    beat_t b;
    logic [DW-1:0] d;
    wb.wbm_dat_i = '0;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_err_i = 1'b0;
    wb.wbm_rty_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (irq_due || irq) begin
          check_output("irq_pulse", irq, irq_due);
          if (irq) irq_seen++;
        end
        if (last_due) check_output("cyc_drop_after_last", wb.wbm_cyc_o, 0);
      end
      irq_due = 1'b0;
      last_due = 1'b0;
      wb.wbm_ack_i = 1'b0;
      wb.wbm_err_i = 1'b0;
      wb.wbm_rty_i = 1'b0;
      if (rst_n && wb.wbm_cyc_o && wb.wbm_stb_o) begin
        if (first_seen < 0) first_seen = cyc_num;
        if (err_on_beat == beat_idx) begin
          wb.wbm_err_i = 1'b1;
          wb.wbm_ack_i = 1'($urandom_range(1));
          err_on_beat = -1;
        end else if (rty_on_beat == beat_idx && rty_done < rty_cycles) begin
          wb.wbm_rty_i = 1'b1;
          rty_done++;
        end else if ($urandom_range(99) < ack_pct) begin
          wb.wbm_ack_i = 1'b1;
        end else if ($urandom_range(3) == 0) begin
          wb.wbm_rty_i = 1'b1;
        end
      end
      #1;
      if (rst_n && wb.wbm_ack_i && !wb.wbm_err_i) begin
        if (exp_q.size() == 0 || exp_data.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat actual adr=0x%0h required no beat", wb.wbm_adr_o);
        end else begin
          b = exp_q.pop_front();
          d = exp_data.pop_front();
          check_output("beat_adr", wb.wbm_adr_o, b.adr);
          check_output("beat_dat", wb.wbm_dat_o, d);
          check_output("beat_cti", wb.wbm_cti_o, b.cti);
          check_output("beat_we_sel_bte", {wb.wbm_we_o, wb.wbm_sel_o, wb.wbm_bte_o}, {1'b1, 4'hF, 2'b00});
          check_output("beat_pop", fifo_rd, 1);
          irq_due = b.wrap;
          last_due = (b.cti == 3'b111);
        end
        beat_idx++;
      end else if (rst_n && (wb.wbm_err_i || wb.wbm_rty_i)) begin
        check_output("no_pop_on_err_rty", fifo_rd, 0);
      end
      pop_now = fifo_rd;
      @(posedge clk);
      #1;
      if (pop_now && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pop_cnt++;
        fifo_refresh();
      end
    end
  end

  initial begin
    #300000;
    checks++;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset state
    #3;
    check_output("rst_busy", busy, 0);
    check_output("rst_tx_cnt", tx_cnt, 0);
    check_output("rst_irq_err", {irq, err}, 0);
    check_output("rst_cyc_stb_we", {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o}, 0);
    check_output("rst_cti", wb.wbm_cti_o, 0);
    check_output("rst_fifo_rd", fifo_rd, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    $display("[TB] plain: NW=8 BL=4 two bursts");
    plan_bursts(32'h0000_1000, 8, 4, 8);
    apply_stimulus(32'h0000_1000, 8, 4, 1'b0, 0, 8);
    wait_idle(400);
    check_output("plain_drained", exp_q.size(), 0);
    check_output("plain_tx_cnt", tx_cnt, 0);
    check_output("plain_pops", pop_cnt, 8);
    check_output("plain_irqs", irq_seen, 1);
    flush_model();

    $display("[TB] single-beat bursts: burst_size 0");
    plan_bursts(32'h0000_2000, 4, 0, 4);
    apply_stimulus(32'h0000_2000, 4, 0, 1'b0, 0, 4);
    wait_idle(300);
    check_output("single_drained", exp_q.size(), 0);
    check_output("single_pops", pop_cnt, 4);
    flush_model();

    $display("[TB] timeout flush: BL=8, 3 words, timeout 10");
    plan_bursts(32'h0000_3000, 8, 3, 3);
    apply_stimulus(32'h0000_3000, 8, 8, 1'b0, 10, 3);
    wait_beats(3, 300);
    repeat (3) @(posedge clk);
    #1;
    check_output("timeout_latency", first_seen - t0, 10);
    check_output("timeout_still_busy", busy, 1);
    pulse_stop();
    wait_idle(10);
    check_output("timeout_tx_cnt", tx_cnt, 3);
    check_output("timeout_drained", exp_q.size(), 0);
    flush_model();

    $display("[TB] ring mode: NW=6 BL=4 cont");
    plan_bursts(32'h0000_4000, 6, 4, 12);
    apply_stimulus(32'h0000_4000, 6, 4, 1'b1, 0, 12);
    wait_beats(12, 600);
    repeat (3) @(posedge clk);
    #1;
    check_output("ring_busy_held", busy, 1);
    check_output("ring_tx_cnt", tx_cnt, 0);
    check_output("ring_irqs", irq_seen, 2);
    pulse_stop();
    wait_idle(10);
    check_output("ring_drained", exp_q.size(), 0);
    flush_model();

    $display("[TB] clamp and address truncation: burst_size 100");
    plan_bursts(32'hFFFF_FFF0, 16, 100, 16);
    apply_stimulus(32'hFFFF_FFF0, 16, 100, 1'b0, 0, 16);
    wait_idle(600);
    check_output("clamp_drained", exp_q.size(), 0);
    check_output("clamp_irqs", irq_seen, 1);
    flush_model();

    $display("[TB] bus error on second beat");
    plan_bursts(32'h0000_5000, 8, 4, 4);
    err_on_beat = 1;
    apply_stimulus(32'h0000_5000, 8, 4, 1'b0, 0, 8);
    wait_idle(300);
    check_output("err_flag", err, 1);
    check_output("err_tx_cnt", tx_cnt, 1);
    check_output("err_pops", pop_cnt, 1);
    check_output("err_remaining_plan", exp_q.size(), 3);
    err_on_beat = -1;
    flush_model();

    $display("[TB] retry on first beat for 3 cycles");
    plan_bursts(32'h0000_6000, 4, 4, 4);
    rty_on_beat = 0;
    rty_cycles = 3;
    rty_done = 0;
    apply_stimulus(32'h0000_6000, 4, 4, 1'b0, 0, 4);
    wait_idle(300);
    check_output("rty_issued", rty_done, 3);
    check_output("rty_drained", exp_q.size(), 0);
    check_output("rty_pops", pop_cnt, 4);
    rty_on_beat = -1;
    flush_model();

    $display("[TB] stop during burst finishes the burst");
    plan_bursts(32'h0000_7000, 8, 4, 4);
    apply_stimulus(32'h0000_7000, 8, 4, 1'b1, 0, 8);
    wait_beats(1, 200);
    pulse_stop();
    wait_idle(300);
    repeat (2) @(posedge clk);
    check_output("stop_drained", exp_q.size(), 0);
    check_output("stop_pops", pop_cnt, 4);
    check_output("stop_tx_cnt", tx_cnt, 4);
    flush_model();

    $display("[TB] async reset mid-burst");
    plan_bursts(32'h0000_8000, 8, 8, 8);
    apply_stimulus(32'h0000_8000, 8, 8, 1'b0, 0, 8);
    wait_beats(2, 300);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_cyc_stb", {wb.wbm_cyc_o, wb.wbm_stb_o}, 0);
    check_output("midrst_cti", wb.wbm_cti_o, 0);
    check_output("midrst_busy_tx", {busy, tx_cnt}, 0);
    check_output("midrst_fifo_rd", fifo_rd, 0);
    @(posedge clk);
    #2;
    check_output("midrst_pops", pop_cnt, 2);
    rst_n = 1'b1;
    flush_model();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
